// File: rtl/cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : cmd_parser
// Description : Byte-stream command parser driving sig_gen configuration
//               registers. Optional checksum byte: CMD_PARSER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_parser #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [2:0]  state,
    output logic [11:0] state_freq,
    output logic [2:0]  state_amp,
    output logic [7:0]  state_phase,
    output logic        cfg_update,
    output logic        frame_err,
    output logic [7:0]  err_count
);

    // The timer only ever holds 0 .. TIMEOUT_CYCLES-1.
    localparam int unsigned        c_timer_w    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_timer_w-1:0] c_timer_last = c_timer_w'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GET_OP  = 3'd1,
        S_GET_D1  = 3'd2,
        S_GET_D0  = 3'd3,
`ifdef CMD_PARSER_CHECKSUM_EN
        S_GET_CHK = 3'd4,
`endif
        S_APPLY   = 3'd5
    } state_t;

    state_t                 r_fsm;
    state_t                 w_fsm_nxt;
    logic [c_timer_w-1:0]   r_timer;
    logic [7:0]             r_op;
    logic [3:0]             r_d1_lo;
    logic [7:0]             r_d0;
    logic [2:0]             r_state;
    logic [11:0]            r_freq;
    logic [2:0]             r_amp;
    logic [7:0]             r_phase;
    logic                   r_cfg_update;
    logic                   r_frame_err;
    logic [7:0]             r_err_count;

    logic                   w_in_frame;
    logic                   w_timeout;
    logic                   w_op_ok;
    logic                   w_chk_ok;
    logic                   w_apply_ok;
    logic                   w_apply_err;
    logic [11:0]            w_freq_word;

`ifdef CMD_PARSER_CHECKSUM_EN
    logic [7:0]             r_sum;
    logic                   r_chk_ok;
    assign w_chk_ok = r_chk_ok;
`else
    assign w_chk_ok = 1'b1;
`endif

    assign w_freq_word = {r_d1_lo, r_d0};
    assign w_in_frame  = (r_fsm != S_IDLE) && (r_fsm != S_APPLY);
    assign w_timeout   = w_in_frame && !rx_valid && (r_timer == c_timer_last);
    assign w_apply_ok  = (r_fsm == S_APPLY) && w_op_ok && w_chk_ok;
    assign w_apply_err = (r_fsm == S_APPLY) && !(w_op_ok && w_chk_ok);

    always_comb begin
        w_op_ok = 1'b0;
        case (r_op)
            8'h01, 8'h03, 8'h04: w_op_ok = 1'b1;
            8'h02:               w_op_ok = (w_freq_word != 12'd0);
            default:             w_op_ok = 1'b0;
        endcase
    end

    // APPLY lasts one cycle and accepts a new SYNC exactly like IDLE does.
    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE, S_APPLY: w_fsm_nxt = (rx_valid && rx_data == SYNC_BYTE) ? S_GET_OP : S_IDLE;
            S_GET_OP:        if (rx_valid) w_fsm_nxt = S_GET_D1;
            S_GET_D1:        if (rx_valid) w_fsm_nxt = S_GET_D0;
`ifdef CMD_PARSER_CHECKSUM_EN
            S_GET_D0:        if (rx_valid) w_fsm_nxt = S_GET_CHK;
            S_GET_CHK:       if (rx_valid) w_fsm_nxt = S_APPLY;
`else
            S_GET_D0:        if (rx_valid) w_fsm_nxt = S_APPLY;
`endif
            default:         w_fsm_nxt = S_IDLE;
        endcase
        if (w_timeout) begin
            w_fsm_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm   <= S_IDLE;
            r_timer <= '0;
        end else begin
            r_fsm <= w_fsm_nxt;
            if (!w_in_frame || rx_valid || w_timeout) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + c_timer_w'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= 8'd0;
            r_d1_lo <= 4'd0;
            r_d0    <= 8'd0;
        end else if (rx_valid) begin
            case (r_fsm)
                S_GET_OP: r_op    <= rx_data;
                S_GET_D1: r_d1_lo <= rx_data[3:0];
                S_GET_D0: r_d0    <= rx_data;
                default:  ;
            endcase
        end
    end

`ifdef CMD_PARSER_CHECKSUM_EN
    // Running XOR of OP, D1 and D0 so only D1[3:0] needs storing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum    <= 8'd0;
            r_chk_ok <= 1'b0;
        end else if (rx_valid) begin
            case (r_fsm)
                S_GET_OP:           r_sum    <= rx_data;
                S_GET_D1, S_GET_D0: r_sum    <= r_sum ^ rx_data;
                S_GET_CHK:          r_chk_ok <= (r_sum == rx_data);
                default:            ;
            endcase
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= 3'd0;
            r_freq       <= 12'd1;
            r_amp        <= 3'd7;
            r_phase      <= 8'd0;
            r_cfg_update <= 1'b0;
            r_frame_err  <= 1'b0;
            r_err_count  <= 8'd0;
        end else begin
            r_cfg_update <= w_apply_ok;
            r_frame_err  <= w_apply_err || w_timeout;
            if ((w_apply_err || w_timeout) && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
            if (w_apply_ok) begin
                case (r_op)
                    8'h01:   r_state <= r_d0[2:0];
                    8'h02:   r_freq  <= w_freq_word;
                    8'h03:   r_amp   <= r_d0[2:0];
                    8'h04:   r_phase <= r_d0;
                    default: ;
                endcase
            end
        end
    end

    assign state       = r_state;
    assign state_freq  = r_freq;
    assign state_amp   = r_amp;
    assign state_phase = r_phase;
    assign cfg_update  = r_cfg_update;
    assign frame_err   = r_frame_err;
    assign err_count   = r_err_count;

endmodule
`default_nettype wire

// File: doc/cmd_parser.md
CMD_PARSER -- requirements
Module: cmd_parser

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning the maximum clk cycles allowed between consecutive bytes inside one frame.
REQ-002 The block SHALL have parameter SYNC_BYTE, default 8'hA5, meaning the frame start marker.
REQ-003 Port clk  input  1  100 MHz system clock.
REQ-004 Port rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-005 Port rx_data  input  8  byte from the USB FIFO reader.
REQ-006 Port rx_valid  input  1  single-cycle strobe; rx_data is valid on this cycle.
REQ-007 Port state  output  3  waveform select to sig_gen.
REQ-008 Port state_freq  output  12  frequency word to sig_gen.
REQ-009 Port state_amp  output  3  amplitude code to sig_gen.
REQ-010 Port state_phase  output  8  phase offset to sig_gen.
REQ-011 Port cfg_update  output  1  one-cycle pulse; a register was written.
REQ-012 Port frame_err  output  1  one-cycle pulse; a frame was discarded.
REQ-013 Port err_count  output  8  saturating count of discarded frames.

Function
REQ-014 Frame format SHALL be SYNC, OP, D1, D0, then CHK when checksum is compiled in; CHK = OP ^ D1 ^ D0.
REQ-015 FSM states SHALL be IDLE, GET_OP, GET_D1, GET_D0, GET_CHK, APPLY; each rx_valid advances exactly one state.
REQ-016 IDLE: rx_valid with rx_data == SYNC_BYTE -> GET_OP; any other byte is dropped silently, with no error.
REQ-017 After D0 (or CHK) is accepted, the FSM SHALL enter APPLY for exactly one cycle, then return to IDLE.
REQ-018 In APPLY, OP 0x01 SHALL write state <= D0[2:0].
REQ-019 In APPLY, OP 0x02 SHALL write state_freq <= {D1[3:0], D0}.
REQ-020 In APPLY, OP 0x03 SHALL write state_amp <= D0[2:0].
REQ-021 In APPLY, OP 0x04 SHALL write state_phase <= D0.
REQ-022 In APPLY, a valid write SHALL update its output on the clk edge leaving APPLY, and cfg_update SHALL be high in that same cycle; latency is 2 cycles from the final byte strobe to the output change.
REQ-023 An unknown OP, or OP 0x02 with state_freq result 0, SHALL write nothing, pulse frame_err, and increment err_count.
REQ-024 An rx_valid arriving during APPLY SHALL be processed as if in IDLE.
REQ-025 Timeout: in GET_OP..GET_CHK, if TIMEOUT_CYCLES cycles pass with no rx_valid -> IDLE, pulse frame_err, increment err_count; the timer SHALL reload on every rx_valid.
REQ-026 A SYNC_BYTE value arriving mid-frame SHALL be treated as data, not as a resync.
REQ-027 err_count SHALL saturate at 255; it SHALL never wrap.
REQ-028 When frame_err and cfg_update would coincide, only one SHALL assert per frame, because a frame either applies or errors.

Reset
REQ-029 rst_n low SHALL immediately force: FSM IDLE, state 0, state_freq 12'd1, state_amp 3'd7, state_phase 0, cfg_update 0, frame_err 0, err_count 0, timer 0.
REQ-030 Reset mid-frame SHALL discard the partial frame with no error pulse after release.
REQ-031 After reset deassertion, the first rx_valid SHALL be evaluated in IDLE.

Configuration
REQ-032 Macro CMD_PARSER_CHECKSUM_EN defined: GET_CHK is used, and a CHK mismatch SHALL discard the frame (frame_err, err_count +1, no write).
REQ-033 Macro CMD_PARSER_CHECKSUM_EN undefined: GET_CHK SHALL be absent, GET_D0 -> APPLY, and the frame is 4 bytes.

Verification
REQ-034 Bytes A5,02,03,E8(,E9) -> state_freq = 12'h3E8 two cycles after the last strobe, with a single cfg_update pulse.
REQ-035 Bytes 00,FF,A5,01,00,02(,03) -> state = 3'd2; the leading junk causes no frame_err.
REQ-036 With checksum compiled in, bytes A5,03,00,05,00 -> state_amp stays 7, frame_err pulses, err_count = 1.
REQ-037 Bytes A5,04 then silence for TIMEOUT_CYCLES -> frame_err pulses; a following A5,04,00,80(,84) sets state_phase = 8'h80.
REQ-038 Send 300 bad-OP frames (A5,09,...) -> err_count = 255, and all outputs keep their reset values.
REQ-039 Assert rst_n low after A5,02,0F -> all outputs return to reset values; the next complete frame applies normally.
